// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth MAC accumulator
package booth_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/boothmul.sv
// rtl/boothmul.sv - combinational radix-4 Booth signed 8x8 multiplier
module boothmul
    import booth_pkg::*;
(
    input  logic signed [OP_W-1:0]   a,
    input  logic signed [OP_W-1:0]   b,
    output logic signed [PROD_W-1:0] prod
);

    logic [OP_W:0]             b_ext;
    logic signed [PROD_W-1:0]  a_ext;

    assign b_ext = {b, 1'b0};
    assign a_ext = {{(PROD_W-OP_W){a[OP_W-1]}}, a};

    // Each overlapping bit triplet of b selects one of {0, +-a, +-2a}, weighted by 4^i.
    always_comb begin
        logic signed [PROD_W-1:0] pp;
        logic signed [PROD_W-1:0] sum;
        pp  = '0;
        sum = '0;
        for (int i = 0; i < OP_W/2; i++) begin
            case (b_ext[2*i +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext <<< 1;
                3'b100:         pp = -(a_ext <<< 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            sum = sum + (pp <<< (2*i));
        end
        prod = sum;
    end

endmodule

// File: rtl/booth_mac_acc.sv
// rtl/booth_mac_acc.sv - pipelined signed dot-product accumulator with saturation
module booth_mac_acc
    import booth_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_a,
    input  logic [OP_W-1:0]         in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_ovf
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   state;
    logic                     run;
    logic                     last_pend;
    logic                     p_valid;
    logic                     p_last;
    logic signed [PROD_W-1:0] p_prod;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf;

    logic                     accept;
    logic signed [ACC_W:0]    sum_w;
    logic                     clamp;
    logic signed [ACC_W-1:0]  acc_next;

    boothmul u_mul (
        .a    (in_a),
        .b    (in_b),
        .prod (prod)
    );

    // run holds in_ready low until the first edge after reset is released.
    assign in_ready = run && (state == ST_ACC) && !last_pend;
    assign accept   = in_valid && in_ready;

    // One guard bit is enough: a single add can overflow by at most one bit.
    assign sum_w    = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){p_prod[PROD_W-1]}}, p_prod};
    assign clamp    = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    assign acc_next = clamp ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            run       <= 1'b0;
            last_pend <= 1'b0;
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            p_prod    <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
        end else begin
            run     <= 1'b1;
            p_valid <= accept;
            if (accept) begin
                p_prod <= prod;
                p_last <= in_last;
                if (in_last) begin
                    last_pend <= 1'b1;
                end
            end
            if (state == ST_ACC && p_valid) begin
                acc <= acc_next;
                ovf <= ovf | clamp;
                if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (p_last) begin
                    state <= ST_DONE;
                end
            end else if (state == ST_DONE && out_ready) begin
                state     <= ST_ACC;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
                last_pend <= 1'b0;
            end
        end
    end

    assign out_valid = (state == ST_DONE);
    assign out_sum   = acc;
    assign out_cnt   = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_booth_mac_acc.sv
// tb/tb_booth_mac_acc.sv - scoreboard bench for booth_mac_acc at ACC_W=24 and ACC_W=16
module tb_booth_mac_acc;

    typedef struct {
        longint sum;
        int     cnt;
        bit     ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_ready;

    logic        rdy24, rdy16, ov24, ov16, of24, of16;
    logic [23:0] sum24;
    logic [15:0] sum16;
    logic [7:0]  cnt24, cnt16;

    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;
    bit   rdy_rand = 1'b0;
    byte  vec_a[$];
    byte  vec_b[$];
    exp_t q24[$];
    exp_t q16[$];
    exp_t e24, e16;

    always #5 clk = ~clk;

    booth_mac_acc #(.ACC_W(24), .CNT_W(8)) dut24 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy24),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov24),
        .out_ready(out_ready), .out_sum(sum24), .out_cnt(cnt24), .out_ovf(of24)
    );

    booth_mac_acc #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov16),
        .out_ready(out_ready), .out_sum(sum16), .out_cnt(cnt16), .out_ovf(of16)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: dot product with clamping after every term, sticky overflow, saturating count.
    function automatic exp_t model(input int w);
        exp_t   e;
        longint hi;
        longint lo;
        hi    = (longint'(1) <<< (w-1)) - 1;
        lo    = -(longint'(1) <<< (w-1));
        e.sum = 0;
        e.ovf = 1'b0;
        foreach (vec_a[i]) begin
            e.sum = e.sum + longint'(vec_a[i]) * longint'(vec_b[i]);
            if (e.sum > hi) begin e.sum = hi; e.ovf = 1'b1; end
            if (e.sum < lo) begin e.sum = lo; e.ovf = 1'b1; end
        end
        e.cnt = (vec_a.size() > 255) ? 255 : vec_a.size();
        return e;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        n        = 0;
        while (1) begin
            @(negedge clk);
            if (rdy24) break;
            stalls++;
            n++;
            if (n > 200) begin
                chk("send_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        vec_a.push_back(a);
        vec_b.push_back(b);
        if (last) begin
            q24.push_back(model(24));
            q16.push_back(model(16));
            vec_a.delete();
            vec_b.delete();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q24.size() + q16.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q24.size() + q16.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rst_n && ov24 && out_ready) begin
            if (q24.size() == 0) chk("unexpected_out24", 1, 0);
            else begin
                e24 = q24.pop_front();
                chk("sum24", longint'($signed(sum24)), e24.sum);
                chk("cnt24", cnt24, e24.cnt);
                chk("ovf24", of24, e24.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov16 && out_ready) begin
            if (q16.size() == 0) chk("unexpected_out16", 1, 0);
            else begin
                e16 = q16.pop_front();
                chk("sum16", longint'($signed(sum16)), e16.sum);
                chk("cnt16", cnt16, e16.cnt);
                chk("ovf16", of16, e16.ovf);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        longint held;
        int     n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready24", rdy24, 0);
        chk("rst_in_ready16", rdy16, 0);
        chk("rst_out_valid24", ov24, 0);
        chk("rst_out_valid16", ov16, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", rdy24, 0);
        @(negedge clk);
        chk("ready_after_first_edge", rdy24, 1);
        @(posedge clk); #1;

        // Small vector with latency check on the last term.
        send(8'd3, 8'd4, 0, 0);
        send(8'hFE, 8'd5, 0, 0);
        send(8'd7, 8'd7, 1, 0);
        @(negedge clk);
        chk("latency_edge1_valid", ov24, 0);
        @(negedge clk);
        chk("latency_edge2_valid", ov24, 1);
        drain();

        send(8'h80, 8'h80, 1, 0);
        send(8'hFF, 8'hFF, 1, 0);
        send(8'h80, 8'h80, 0, 0);
        send(8'h80, 8'h80, 0, 0);
        send(8'h80, 8'h80, 1, 0);
        send(8'd1, 8'd1, 1, 0);
        drain();

        // Consumer back-pressure holds the result stable and blocks new input.
        out_ready = 1'b0;
        send(8'd5, 8'd6, 1, 0);
        n = 0;
        while (!ov24 && n < 20) begin @(negedge clk); n++; end
        chk("bp_valid_rose", ov24, 1);
        held = longint'($signed(sum24));
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", ov24, 1);
            chk("bp_sum_held", longint'($signed(sum24)), held);
            chk("bp_in_ready_low", rdy24, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_edge_in_ready", rdy24, 0);
        @(negedge clk);
        chk("after_hs_in_ready", rdy24, 1);
        chk("after_hs_valid", ov24, 0);
        @(posedge clk); #1;

        rdy_rand = 1'b1;
        for (int v = 0; v < 12; v++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int t = 0; t < len; t++) begin
                logic [7:0] ra, rb;
                ra = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom);
                rb = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom);
                send(ra, rb, t == len - 1, $urandom_range(0, 2));
            end
        end
        rdy_rand = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        stalls = 0;
        for (int t = 0; t < 300; t++) send(8'd1, 8'd1, t == 299, 0);
        chk("stream_stalls", stalls, 0);
        drain();

        // Reset in the middle of a vector discards the partial sum.
        send(8'd10, 8'd10, 0, 0);
        send(8'd10, 8'd10, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid24", ov24, 0);
        chk("midrst_valid16", ov16, 0);
        chk("midrst_in_ready", rdy24, 0);
        vec_a.delete();
        vec_b.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'd2, 8'd3, 1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
